// File: rtl/imem_axil_rd_slave_pkg.sv
// Shared types and constants for the imem AXI-lite read responder.
// Holds the FSM state encoding, response codes and wait-counter width.
package imem_axil_rd_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

endpackage

// File: rtl/imem_axil_rd_slave_lat.sv
// Loadable 4-bit down-counter that times the programmable response wait.
// o_done flags the last wait cycle (count of one).
module imem_lat_cnt
  import imem_axil_rd_slave_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: load wins, otherwise count down and stop at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != CNT_ZERO) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == CNT_ONE);

endmodule

// File: rtl/imem_axil_rd_slave.sv
// AXI-lite read-channel subordinate for instruction memory: one outstanding read,
// synchronous SRAM fetch, programmable wait, then a held R beat.
module imem_axil_rd_slave
  import imem_axil_rd_slave_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 64,
  parameter logic [ADDR_W-1:0]    BASE     = 32'h8000_0000,
  parameter int unsigned          SIZE_LG2 = 27,
  parameter int unsigned          LATENCY  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_arvalid,
  input  logic [ADDR_W-1:0]     i_araddr,
  output logic                  o_arready,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [DATA_W-1:0]     o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_mem_ren,
  output logic [SIZE_LG2-4:0]   o_mem_addr,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  if (LATENCY > 15) begin : g_lat_chk
    $error("imem_axil_rd_slave: LATENCY must be in 0..15");
  end

  localparam logic [CNT_W-1:0] LAT_V = LATENCY[CNT_W-1:0];

  state_e              r_state;
  state_e              w_next_state;
  logic                r_hit;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic                w_accept;
  logic                w_hit;
  logic                w_cnt_load;
  logic                w_cnt_done;
  logic [ADDR_W-1:0]   w_offset;
  logic [ADDR_W-1:0]   w_dw;

  // Offset wraps modulo 2^ADDR_W, so addresses below BASE land far above the window and miss.
  assign w_offset   = i_araddr - BASE;
  assign w_dw       = w_offset >> 3;
  assign w_hit      = (w_dw[ADDR_W-1:SIZE_LG2-3] == '0);
  assign o_mem_addr = w_dw[SIZE_LG2-4:0];
  assign w_accept   = i_arvalid & o_arready;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_arvalid) w_next_state = ST_FETCH;
        else           w_next_state = ST_IDLE;
      end
      ST_FETCH: begin
        if (LATENCY != 0) w_next_state = ST_WAIT;
        else              w_next_state = ST_RESP;
      end
      ST_WAIT: begin
        if (w_cnt_done) w_next_state = ST_RESP;
        else            w_next_state = ST_WAIT;
      end
      ST_RESP: begin
        if (i_rready && i_arvalid) w_next_state = ST_FETCH;
        else if (i_rready)         w_next_state = ST_IDLE;
        else                       w_next_state = ST_RESP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode; ARREADY reopens in RESP during the R handshake to avoid a bubble.
  always_comb begin
    o_arready  = 1'b0;
    o_rvalid   = 1'b0;
    w_cnt_load = 1'b0;
    case (r_state)
      ST_IDLE:  o_arready  = 1'b1;
      ST_FETCH: w_cnt_load = 1'b1;
      ST_WAIT:  o_arready  = 1'b0;
      ST_RESP: begin
        o_rvalid  = 1'b1;
        o_arready = i_rready;
      end
      default: o_arready = 1'b0;
    endcase
    o_mem_ren = w_accept & w_hit;
  end

  // Response registers: hit flag at AR accept, data/resp captured in FETCH and held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit   <= 1'b0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else begin
      if (w_accept) r_hit <= w_hit;
      else          r_hit <= r_hit;
      if (r_state == ST_FETCH) begin
        r_rdata <= r_hit ? i_mem_rdata : '0;
        r_rresp <= r_hit ? RESP_OKAY : RESP_DECERR;
      end else begin
        r_rdata <= r_rdata;
        r_rresp <= r_rresp;
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_rresp = r_rresp;

  imem_lat_cnt u_lat_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_cnt_load),
    .i_val  (LAT_V),
    .o_done (w_cnt_done)
  );

endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// Directed bench for imem_axil_rd_slave: three instances (LATENCY 1, 0, 3) share
// the AR/R stimulus; each has its own SRAM model.
module tb_imem_axil_rd_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = 32'h0;
  logic        rready = 1'b0;

  logic        arready0, arready1, arready2;
  logic        rvalid0, rvalid1, rvalid2;
  logic [63:0] rdata0, rdata1, rdata2;
  logic [1:0]  rresp0, rresp1, rresp2;
  logic        ren0, ren1, ren2;
  logic [23:0] maddr0, maddr1, maddr2;
  logic [63:0] mrd0 = 64'h0, mrd1 = 64'h0, mrd2 = 64'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [23:0] idx);
    if (idx == 24'd0) return 64'h1122_3344_5566_7788;
    return {8'hA5, 32'h0, idx};
  endfunction

  always @(posedge clk) if (ren0) mrd0 <= mem_word(maddr0);
  always @(posedge clk) if (ren1) mrd1 <= mem_word(maddr1);
  always @(posedge clk) if (ren2) mrd2 <= mem_word(maddr2);

  imem_axil_rd_slave #(.LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(rst), .i_arvalid(arvalid), .i_araddr(araddr), .o_arready(arready0),
    .o_rvalid(rvalid0), .i_rready(rready), .o_rdata(rdata0), .o_rresp(rresp0),
    .o_mem_ren(ren0), .o_mem_addr(maddr0), .i_mem_rdata(mrd0));

  imem_axil_rd_slave #(.LATENCY(0)) u_l0 (
    .i_clk(clk), .i_rst(rst), .i_arvalid(arvalid), .i_araddr(araddr), .o_arready(arready1),
    .o_rvalid(rvalid1), .i_rready(rready), .o_rdata(rdata1), .o_rresp(rresp1),
    .o_mem_ren(ren1), .o_mem_addr(maddr1), .i_mem_rdata(mrd1));

  imem_axil_rd_slave #(.LATENCY(3)) u_l3 (
    .i_clk(clk), .i_rst(rst), .i_arvalid(arvalid), .i_araddr(araddr), .o_arready(arready2),
    .o_rvalid(rvalid2), .i_rready(rready), .o_rdata(rdata2), .o_rresp(rresp2),
    .o_mem_ren(ren2), .o_mem_addr(maddr2), .i_mem_rdata(mrd2));

  // Instance selectors: 0 -> LATENCY 1, 1 -> LATENCY 0, 2 -> LATENCY 3.
  function automatic logic ar(input int k);
    case (k) 0: return arready0; 1: return arready1; default: return arready2; endcase
  endfunction
  function automatic logic rv(input int k);
    case (k) 0: return rvalid0; 1: return rvalid1; default: return rvalid2; endcase
  endfunction
  function automatic logic [63:0] rd(input int k);
    case (k) 0: return rdata0; 1: return rdata1; default: return rdata2; endcase
  endfunction
  function automatic logic [1:0] rr(input int k);
    case (k) 0: return rresp0; 1: return rresp1; default: return rresp2; endcase
  endfunction
  function automatic logic rn(input int k);
    case (k) 0: return ren0; 1: return ren1; default: return ren2; endcase
  endfunction
  function automatic logic [23:0] ma(input int k);
    case (k) 0: return maddr0; 1: return maddr1; default: return maddr2; endcase
  endfunction

  // One AR with RREADY=1; returns what was seen, lat = cycles from AR to first RVALID.
  task automatic issue_read(input int k, input logic [31:0] addr, output logic ar_ok,
                            output logic ren_ok, output logic [23:0] m_a, output int lat,
                            output logic [63:0] data, output logic [1:0] resp);
    @(negedge clk); arvalid = 1'b1; araddr = addr; rready = 1'b1; #1;
    ar_ok = ar(k); ren_ok = rn(k); m_a = ma(k);
    lat = 99; data = 64'h0; resp = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); arvalid = 1'b0; #1;
      if (rv(k)) begin lat = c; data = rd(k); resp = rr(k); break; end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", rvalid0); end
    checks++; if (rdata0 !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata0); end
    checks++; if (rresp0 !== 2'b00) begin failures++; $display("FAIL rst_rresp got=%b exp=00", rresp0); end
    checks++; if (ren0 !== 1'b0) begin failures++; $display("FAIL rst_mem_ren got=%b exp=0", ren0); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (arready0 !== 1'b1) begin failures++; $display("FAIL rst_arready got=%b exp=1", arready0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_hit();
    logic a, r; logic [23:0] m; int l; logic [63:0] d; logic [1:0] s;
    issue_read(0, 32'h8000_0000, a, r, m, l, d, s);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL hit_arready got=%b exp=1", a); end
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL hit_mem_ren got=%b exp=1", r); end
    checks++; if (m !== 24'h0) begin failures++; $display("FAIL hit_mem_addr got=%h exp=0", m); end
    checks++; if (l != 3) begin failures++; $display("FAIL hit_latency got=%0d exp=3", l); end
    checks++; if (d !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL hit_rdata got=%h exp=1122334455667788", d); end
    checks++; if (s !== 2'b00) begin failures++; $display("FAIL hit_rresp got=%b exp=00", s); end
  endtask

  task automatic test_decerr();
    logic a, r; logic [23:0] m; int l; logic [63:0] d; logic [1:0] s;
    logic [31:0] addrs [2];
    addrs[0] = 32'h7FFF_FFFC; addrs[1] = 32'h8800_0000;
    for (int i = 0; i < 2; i++) begin
      issue_read(0, addrs[i], a, r, m, l, d, s);
      checks++; if (r !== 1'b0) begin failures++; $display("FAIL decerr_mem_ren[%0d] got=%b exp=0", i, r); end
      checks++; if (l != 3) begin failures++; $display("FAIL decerr_latency[%0d] got=%0d exp=3", i, l); end
      checks++; if (d !== 64'h0) begin failures++; $display("FAIL decerr_rdata[%0d] got=%h exp=0", i, d); end
      checks++; if (s !== 2'b11) begin failures++; $display("FAIL decerr_rresp[%0d] got=%b exp=11", i, s); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk); arvalid = 1'b1; araddr = 32'h8000_0008; rready = 1'b0; #1;
    checks++; if (arready1 !== 1'b1) begin failures++; $display("FAIL bp_arready_idle got=%b exp=1", arready1); end
    @(negedge clk); araddr = 32'h8000_0010; #1;
    checks++; if (arready1 !== 1'b0) begin failures++; $display("FAIL bp_arready_fetch got=%b exp=0", arready1); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'hA500_0000_0000_0001 || arready1 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got rv=%b rd=%h ar=%b exp rv=1 rd=a500000000000001 ar=0", c, rvalid1, rdata1, arready1);
      end
    end
    @(negedge clk); arvalid = 1'b0; rready = 1'b1; #1;
    checks++; if (rvalid1 !== 1'b1 || arready1 !== 1'b1) begin failures++; $display("FAIL bp_release got rv=%b ar=%b exp rv=1 ar=1", rvalid1, arready1); end
    @(negedge clk); #1;
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL bp_done got=%b exp=0", rvalid1); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); arvalid = 1'b1; araddr = 32'h8000_0000; rready = 1'b1; #1;
    checks++; if (arready1 !== 1'b1) begin failures++; $display("FAIL b2b_ar0 got=%b exp=1", arready1); end
    @(negedge clk); araddr = 32'h8000_0008; #1;
    checks++; if (rvalid1 !== 1'b0 || arready1 !== 1'b0) begin failures++; $display("FAIL b2b_fetch got rv=%b ar=%b exp 0 0", rvalid1, arready1); end
    @(negedge clk); #1;
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL b2b_beat0 got rv=%b rd=%h exp rv=1 rd=1122334455667788", rvalid1, rdata1); end
    checks++; if (arready1 !== 1'b1 || ren1 !== 1'b1 || maddr1 !== 24'h1) begin failures++; $display("FAIL b2b_ar1 got ar=%b ren=%b ma=%h exp 1 1 000001", arready1, ren1, maddr1); end
    @(negedge clk); arvalid = 1'b0; #1;
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", rvalid1); end
    @(negedge clk); #1;
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'hA500_0000_0000_0001) begin failures++; $display("FAIL b2b_beat1 got rv=%b rd=%h exp rv=1 rd=a500000000000001", rvalid1, rdata1); end
    @(negedge clk); #1;
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", rvalid1); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int stale; logic a, r; logic [23:0] m; int l; logic [63:0] d; logic [1:0] s;
    @(negedge clk); arvalid = 1'b1; araddr = 32'h8000_0008; rready = 1'b1;
    @(negedge clk); arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (rvalid2 !== 1'b0 || arready2 !== 1'b1) begin failures++; $display("FAIL arst_abort got rv=%b ar=%b exp rv=0 ar=1", rvalid2, arready2); end
    @(negedge clk); rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (rvalid2 !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL arst_stale got=%0d exp=0", stale); end
    issue_read(2, 32'h8000_0010, a, r, m, l, d, s);
    checks++; if (l != 5) begin failures++; $display("FAIL arst_latency got=%0d exp=5", l); end
    checks++; if (d !== 64'hA500_0000_0000_0002 || s !== 2'b00) begin failures++; $display("FAIL arst_data got rd=%h rr=%b exp rd=a500000000000002 rr=00", d, s); end
  endtask

  task automatic test_boundary();
    logic a, r; logic [23:0] m; int l; logic [63:0] d; logic [1:0] s;
    issue_read(0, 32'h87FF_FFF8, a, r, m, l, d, s);
    checks++; if (r !== 1'b1 || m !== 24'hFF_FFFF) begin failures++; $display("FAIL last_dw_addr got ren=%b ma=%h exp ren=1 ma=ffffff", r, m); end
    checks++; if (d !== 64'hA500_0000_00FF_FFFF || s !== 2'b00) begin failures++; $display("FAIL last_dw_data got rd=%h rr=%b exp rd=a500000000ffffff rr=00", d, s); end
    issue_read(0, 32'h8000_0004, a, r, m, l, d, s);
    checks++; if (r !== 1'b1 || m !== 24'h0) begin failures++; $display("FAIL unaligned_addr got ren=%b ma=%h exp ren=1 ma=000000", r, m); end
    checks++; if (d !== 64'h1122_3344_5566_7788 || s !== 2'b00) begin failures++; $display("FAIL unaligned_data got rd=%h rr=%b exp rd=1122334455667788 rr=00", d, s); end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_decerr();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
